// File: rtl/uart_rx_32b.sv
// 8N1 UART receiver with 16x oversampling. Four accepted bytes, least-significant byte
// first, form one 32-bit word. A partial word is discarded after a long idle gap.
module uart_rx_32b #(
    parameter int NB_DATA         = 32,
    parameter int NB_BYTE         = 8,
    parameter int BAUD_DIV        = 650,
    parameter int N_TICKS_PER_BIT = 16,
    parameter int TIMEOUT_BITS    = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic [NB_BYTE-1:0] o_byte,
    output logic               o_rx_done_8b_pulse,
    output logic               o_rx_done_32b_pulse,
    output logic               o_frame_error_pulse,
    output logic               o_timeout_pulse,
    output logic [1:0]         o_byte_count
);
    localparam int DIV_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int S_W      = $clog2(N_TICKS_PER_BIT);
    localparam int N_W      = (NB_BYTE > 1) ? $clog2(NB_BYTE) : 1;
    localparam int TO_TICKS = TIMEOUT_BITS * N_TICKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
    localparam logic [S_W-1:0]   S_MID    = S_W'(N_TICKS_PER_BIT / 2 - 1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(N_TICKS_PER_BIT - 1);
    localparam logic [N_W-1:0]   N_LAST   = N_W'(NB_BYTE - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_TICKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                     state;
    logic                       rx_meta, rx_s;
    logic [DIV_W-1:0]           div_cnt;
    logic                       tick;
    logic [S_W-1:0]             s;
    logic [N_W-1:0]             n;
    logic [NB_BYTE-1:0]         shreg;
    logic [NB_DATA-NB_BYTE-1:0] word;
    logic [TO_W-1:0]            to_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge i_clock) begin
        if (i_reset || tick) div_cnt <= '0;
        else                 div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state               <= IDLE;
            s                   <= '0;
            n                   <= '0;
            shreg               <= '0;
            word                <= '0;
            to_cnt              <= '0;
            o_data              <= '0;
            o_byte              <= '0;
            o_byte_count        <= '0;
            o_rx_done_8b_pulse  <= 1'b0;
            o_rx_done_32b_pulse <= 1'b0;
            o_frame_error_pulse <= 1'b0;
            o_timeout_pulse     <= 1'b0;
        end else begin
            o_rx_done_8b_pulse  <= 1'b0;
            o_rx_done_32b_pulse <= 1'b0;
            o_frame_error_pulse <= 1'b0;
            o_timeout_pulse     <= 1'b0;
            case (state)
                IDLE: begin
                    // Start detection wins over a timeout landing on the same cycle.
                    if (!rx_s) begin
                        state  <= START;
                        s      <= '0;
                        to_cnt <= '0;
                    end else if (o_byte_count != 2'd0 && tick) begin
                        if (to_cnt == TO_LAST) begin
                            o_timeout_pulse <= 1'b1;
                            o_byte_count    <= '0;
                            to_cnt          <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                START: if (tick) begin
                    if (s == S_MID) begin
                        s     <= '0;
                        n     <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        s <= s + 1'b1;
                    end
                end
                DATA: if (tick) begin
                    if (s == S_LAST) begin
                        s     <= '0;
                        shreg <= {rx_s, shreg[NB_BYTE-1:1]};
                        n     <= n + 1'b1;
                        if (n == N_LAST) state <= STOP;
                    end else begin
                        s <= s + 1'b1;
                    end
                end
                STOP: if (tick) begin
                    if (s == S_LAST) begin
                        s     <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            o_byte             <= shreg;
                            o_rx_done_8b_pulse <= 1'b1;
                            if (o_byte_count == 2'd3) begin
                                o_data              <= {shreg, word};
                                o_rx_done_32b_pulse <= 1'b1;
                                o_byte_count        <= '0;
                            end else begin
                                for (int i = 0; i < 3; i++)
                                    if (o_byte_count == 2'(i)) word[i*NB_BYTE +: NB_BYTE] <= shreg;
                                o_byte_count <= o_byte_count + 1'b1;
                            end
                        end else begin
                            o_frame_error_pulse <= 1'b1;
                            o_byte_count        <= '0;
                        end
                    end else begin
                        s <= s + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
